// File: rtl/c64_key_event_encoder.sv
// C64 keyboard matrix scanner: one key is examined per ena1MHz tick, and each make/break change is queued as a 7-bit event.
// Build option C64KEY_EVENT_FIFO_EN selects a FIFO_DEPTH-entry FIFO. Without it, the queue is a single holding register.
module c64_key_event_encoder #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        sysclk,
    input  logic        n_reset,
    input  logic        ena1MHz,
    input  logic [63:0] keys,
    input  logic        ev_ready,
    output logic        ev_valid,
    output logic [6:0]  ev_code,
    output logic [4:0]  ev_level
);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("FIFO_DEPTH must be a power of two in 2..16");
    end

    logic [63:0] reported_q;
    logic [63:0] reported_d;
    logic [5:0]  idx_q;
    logic [5:0]  idx_d;

    logic        key_now;
    logic        mismatch;
    logic        full;
    logic        push;
    logic        pop;
    logic [6:0]  push_code;

    always_comb begin
        key_now   = keys[idx_q];
        mismatch  = (key_now != reported_q[idx_q]);
        // A full queue blocks the push even if a pop happens on the same edge.
        push      = ena1MHz && mismatch && !full;
        pop       = ev_valid && ev_ready;
        push_code = {key_now, idx_q};
    end

    // The scan index holds on a blocked mismatch so that the same key is retried on the next tick.
    always_comb begin
        reported_d = reported_q;
        idx_d      = idx_q;
        if (push) begin
            reported_d[idx_q] = key_now;
        end
        if (ena1MHz && (!mismatch || push)) begin
            idx_d = idx_q + 6'd1;
        end
    end

    always_ff @(posedge sysclk or negedge n_reset) begin
        if (!n_reset) begin
            reported_q <= '1;
            idx_q      <= '0;
        end else begin
            reported_q <= reported_d;
            idx_q      <= idx_d;
        end
    end

`ifdef C64KEY_EVENT_FIFO_EN

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  DEPTH_L = 5'(FIFO_DEPTH);

    logic [6:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic [4:0]    count_q;
    logic [4:0]    count_d;

    always_comb begin
        full     = (count_q == DEPTH_L);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge sysclk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the outputs mask it whenever count_q is zero.
    always_ff @(posedge sysclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_code;
        end
    end

    always_comb begin
        ev_valid = (count_q != 5'd0);
        ev_code  = ev_valid ? mem_q[rd_ptr_q] : '0;
        ev_level = count_q;
    end

`else

    logic       hold_valid_q;
    logic       hold_valid_d;
    logic [6:0] hold_code_q;
    logic [6:0] hold_code_d;

    always_comb begin
        full         = hold_valid_q;
        hold_valid_d = hold_valid_q;
        hold_code_d  = hold_code_q;
        if (pop) begin
            hold_valid_d = 1'b0;
            hold_code_d  = '0;
        end
        if (push) begin
            hold_valid_d = 1'b1;
            hold_code_d  = push_code;
        end
    end

    always_ff @(posedge sysclk or negedge n_reset) begin
        if (!n_reset) begin
            hold_valid_q <= 1'b0;
            hold_code_q  <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_code_q  <= hold_code_d;
        end
    end

    always_comb begin
        ev_valid = hold_valid_q;
        ev_code  = hold_valid_q ? hold_code_q : '0;
        ev_level = {4'b0000, hold_valid_q};
    end

`endif

endmodule
